// File: rtl/mdu_sequencer_if.sv
// EX-stage <-> MDU bundle: request, operands, flush and the
// stall/result/HI/LO signals returned to the pipeline.
interface mdu_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, funct, srca, srcb, flush,
    input  stall, busy, done, rdata, hi, lo
  );

  modport slave (
    input  start, funct, srca, srcb, flush,
    output stall, busy, done, rdata, hi, lo
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative shift-add multiply / restoring divide with HI/LO file.
// One step per cycle over WIDTH cycles, then a sign fixup cycle.
module mdu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  mdu_sequencer_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opd;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               is_div, neg_q, neg_r;

  logic f_mfhi, f_mthi, f_mflo, f_mtlo;
  logic f_mult, f_multu, f_div, f_divu;
  logic valid, mdu_op, busy, accept, start_md;
  logic sgn_op, div_op, div0, sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b, lat_a;

  assign f_mfhi  = bus.funct == F_MFHI;
  assign f_mthi  = bus.funct == F_MTHI;
  assign f_mflo  = bus.funct == F_MFLO;
  assign f_mtlo  = bus.funct == F_MTLO;
  assign f_mult  = bus.funct == F_MULT;
  assign f_multu = bus.funct == F_MULTU;
  assign f_div   = bus.funct == F_DIV;
  assign f_divu  = bus.funct == F_DIVU;

  assign valid = f_mfhi | f_mthi | f_mflo | f_mtlo
               | f_mult | f_multu | f_div | f_divu;

  assign mdu_op   = bus.start & valid;
  assign busy     = state != IDLE;
  assign accept   = mdu_op & ~busy & ~bus.flush;
  assign start_md = accept & (f_mult | f_multu | f_div | f_divu);

  assign sgn_op = f_mult | f_div;
  assign div_op = f_div | f_divu;
  assign div0   = div_op & (bus.srcb == '0);
  assign sa     = sgn_op & bus.srca[WIDTH-1];
  assign sb     = sgn_op & bus.srcb[WIDTH-1];
  assign abs_a  = sa ? -bus.srca : bus.srca;
  assign abs_b  = sb ? -bus.srcb : bus.srcb;
  // A zero divisor shifts the raw dividend into the remainder unchanged.
  assign lat_a  = div0 ? bus.srca : abs_a;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_md) state_nx = CALC;
      CALC: begin
        if (bus.flush)       state_nx = IDLE;
        else if (cnt == '0)  state_nx = FIXUP;
      end
      FIXUP:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  logic [WIDTH:0]     mul_sum, rsh, diff;
  logic [2*WIDTH-1:0] mul_nx, div_nx, step, mul_res;
  logic [WIDTH-1:0]   q, r, fix_hi, fix_lo;

  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
            + (acc[0] ? {1'b0, opd} : '0);
    mul_nx  = {mul_sum, acc[WIDTH-1:1]};
    rsh     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = rsh - {1'b0, opd};
    div_nx  = diff[WIDTH]
            ? {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
            : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    step    = is_div ? div_nx : mul_nx;
    mul_res = neg_q ? -acc : acc;
    q       = acc[WIDTH-1:0];
    r       = acc[2*WIDTH-1:WIDTH];
    fix_hi  = is_div ? (neg_r ? -r : r) : mul_res[2*WIDTH-1:WIDTH];
    fix_lo  = is_div ? (neg_q ? -q : q) : mul_res[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      acc    <= '0;
      opd    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      if (accept & f_mthi) hi_q <= bus.srca;
      if (accept & f_mtlo) lo_q <= bus.srca;
      if (start_md) begin
        acc    <= {{WIDTH{1'b0}}, div_op ? lat_a : abs_b};
        opd    <= div_op ? abs_b : abs_a;
        is_div <= div_op;
        neg_q  <= ~div0 & (sa ^ sb);
        neg_r  <= ~div0 & div_op & sa;
        cnt    <= CNT_TOP;
      end else if (state == CALC && !bus.flush) begin
        acc <= step;
        cnt <= cnt - 1'b1;
      end
      if (state == FIXUP && !bus.flush) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end
    end
  end

  assign bus.busy  = busy;
  assign bus.stall = mdu_op & busy;
  assign bus.done  = (state == FIXUP) & ~bus.flush;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.rdata = f_mfhi ? hi_q : (f_mflo ? lo_q : '0);

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: arithmetic reference model checked every
// cycle, plus literal expectations from hand-worked vectors.
module tb_mdu_sequencer;

  localparam int W = 32;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] MTLO  = 6'b010011;
  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mdu_sequencer_if #(.WIDTH(W)) bus();
  mdu_sequencer #(.WIDTH(W)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int bcnt = 0;
  int dcnt = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_mdu(logic [5:0] f);
    return f inside {MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU};
  endfunction

  function automatic logic [63:0] calc(logic [5:0] f,
                                       logic [31:0] a, logic [31:0] b);
    logic [63:0] res;
    longint sp;
    int q, rm;
    res = '0;
    case (f)
      MULT: begin
        sp  = longint'($signed(a)) * longint'($signed(b));
        res = sp;
      end
      MULTU: res = {32'b0, a} * {32'b0, b};
      DIV: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF)
          res = {32'h0, 32'h80000000};
        else begin
          q   = $signed(a) / $signed(b);
          rm  = $signed(a) % $signed(b);
          res = {rm, q};
        end
      end
      DIVU: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else        res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // Model: an accepted op occupies W+1 cycles, results land after.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int m_left;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hi <= '0; m_lo <= '0; m_left <= 0;
      p_hi <= '0; p_lo <= '0;
    end else if (m_left > 0) begin
      if (bus.flush) m_left <= 0;
      else if (m_left == 1) begin
        m_hi <= p_hi; m_lo <= p_lo; m_left <= 0;
      end else m_left <= m_left - 1;
    end else if (bus.start && is_mdu(bus.funct) && !bus.flush) begin
      case (bus.funct)
        MTHI: m_hi <= bus.srca;
        MTLO: m_lo <= bus.srca;
        MULT, MULTU, DIV, DIVU: begin
          {p_hi, p_lo} <= calc(bus.funct, bus.srca, bus.srcb);
          m_left <= W + 1;
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    logic es;
    logic [31:0] er;
    if (reset_n) begin
      es = bus.start && is_mdu(bus.funct) && m_left > 0;
      er = (bus.funct == MFHI) ? m_hi : (bus.funct == MFLO) ? m_lo : '0;
      chk("busy", bus.busy, m_left > 0);
      chk("done", bus.done, m_left == 1 && !bus.flush);
      chk("stall", bus.stall, es);
      chk("hi", bus.hi, m_hi);
      chk("lo", bus.lo, m_lo);
      if (!es) chk("rdata", bus.rdata, er);
      if (bus.busy) bcnt++;
      if (bus.done) dcnt++;
    end
  end

  task automatic issue(logic [5:0] f, logic [31:0] a, logic [31:0] b);
    bus.start = 1'b1; bus.funct = f; bus.srca = a; bus.srcb = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.funct = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("idle_timeout", bus.busy, 1'b0);
  endtask

  task automatic run(string nm, logic [5:0] f, logic [31:0] a,
                     logic [31:0] b, logic [31:0] ehi, logic [31:0] elo);
    bcnt = 0; dcnt = 0;
    issue(f, a, b);
    wait_idle();
    chk({nm, "_hi"}, bus.hi, ehi);
    chk({nm, "_lo"}, bus.lo, elo);
    chk({nm, "_busycyc"}, bcnt, 33);
    chk({nm, "_done"}, dcnt, 1);
  endtask

  initial begin
    int s;
    bus.start = 0; bus.funct = '0; bus.srca = '0; bus.srcb = '0;
    bus.flush = 0;
    #2;
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;

    run("mult", MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run("multu", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
        32'hFFFFFFFE, 32'h1);
    run("divu", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run("div", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run("divovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run("divu0", DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF);
    run("div0s", DIV, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF);

    // MFLO right behind a MULT must stall until busy drops.
    issue(MULT, 32'd6, 32'd7);
    bus.start = 1'b1; bus.funct = MFLO;
    s = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.stall) break;
      s++;
    end
    #1;
    chk("mflo_stallcyc", s, 33);
    chk("mflo_rdata", bus.rdata, 42);
    chk("mflo_busy", bus.busy, 0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.funct = '0;

    issue(MTHI, 32'h1234, 32'h0);
    issue(MTLO, 32'h5678, 32'h0);
    chk("mt_hi", bus.hi, 32'h1234);
    chk("mt_lo", bus.lo, 32'h5678);

    // Flush on the accepting edge starts nothing.
    bus.flush = 1'b1;
    issue(MULT, 32'd3, 32'd3);
    bus.flush = 1'b0;
    chk("flush_acc_busy", bus.busy, 0);

    dcnt = 0;
    issue(DIV, 32'd10, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_busy", bus.busy, 0);
    repeat (40) begin @(posedge clk); #1; end
    chk("flush_done", dcnt, 0);
    chk("flush_hi", bus.hi, 32'h1234);
    chk("flush_lo", bus.lo, 32'h5678);

    issue(MULT, 32'd5, 32'd7);
    repeat (5) begin @(posedge clk); #1; end
    #2 reset_n = 1'b0;
    #1;
    chk("arst_hi", bus.hi, 0);
    chk("arst_lo", bus.lo, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    run("post_rst", MULTU, 32'd2, 32'd3, 32'd0, 32'd6);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Iterative multiply/divide unit and HI/LO register file for the pipelined MIPS core. Sits beside the EX-stage ALU.
- Decodes R-type funct codes MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- Runs a WIDTH-cycle shift-add multiply or restoring divide.
- Raises a combinational stall so the hazard logic holds the pipeline when an MDU instruction arrives while an operation is in flight.

Parameters:
WIDTH, 32, operand/HI/LO width; CALC iteration count equals WIDTH.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
start  in  1  EX stage holds a valid R-type MDU instruction this cycle
funct  in  6  instruction funct field
srca  in  WIDTH  rs operand (dividend/multiplicand, MT source)
srcb  in  WIDTH  rt operand (divisor/multiplier)
flush  in  1  pipeline flush; aborts an in-flight operation
stall  out  1  hold IF/ID/EX; combinational
busy  out  1  operation in flight
done  out  1  one-cycle pulse when HI/LO are updated by MULT/DIV
rdata  out  WIDTH  MFHI/MFLO result to the EX result mux; combinational
hi  out  WIDTH  architectural HI
lo  out  WIDTH  architectural LO

Behaviour:
- Reset: clk and reset_n form the only clock/reset pair; reset is asynchronous and active-low. On reset, hi = 0, lo = 0, busy = 0, done = 0, state = IDLE and working registers = 0. Reset mid-operation abandons the operation.
- Funct codes: MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011. Any other funct makes the unit ignore start.
- mdu_op = start and funct is one of the eight codes above.
- stall = mdu_op & busy. While stalled, the instruction is not accepted; the pipeline re-presents it every cycle until busy falls.
- rdata = hi when funct = MFHI, lo when funct = MFLO, else 0. It is valid only when stall = 0.
- MTHI/MTLO: when mdu_op & !busy, write srca to hi or lo at the clock edge.
- State machine, IDLE -> CALC -> FIXUP -> IDLE:
  - IDLE: when mdu_op & !busy & funct is MULT/MULTU/DIV/DIVU, latch the operands into working registers and go to CALC.
    - Signed ops latch magnitudes plus result-sign flags: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
    - busy = 1 from the next cycle.
  - CALC: one shift-add (multiply) or restore-subtract (divide) step per cycle.
    - A counter runs from WIDTH-1 down to 0; after the step at count 0, go to FIXUP.
    - The working product/quotient/remainder are kept separate from hi/lo, so hi/lo stay unchanged during CALC.
  - FIXUP: apply two's-complement negation per the sign flags, then write hi/lo at the clock edge. done = 1 in this cycle. Next state is IDLE with busy = 0.
- Latency:
  - Accepting edge at cycle N; busy is high in cycles N+1 .. N+WIDTH+1 (WIDTH+1 cycles).
  - hi/lo hold new values from cycle N+WIDTH+2.
  - An MDU instruction presented in cycle N+WIDTH+2 is accepted without stall.
- Multiply: the 2*WIDTH-bit result goes {hi,lo} = product. Signed uses the full two's-complement product.
- Divide:
  - lo = quotient, hi = remainder; signed division truncates toward zero.
  - Remainder sign follows the dividend.
  - Divide by zero: the full latency still applies; lo = all ones, hi = srca as latched (raw bits). No sign fixup.
  - Signed overflow (-2^(WIDTH-1) / -1): lo = 0x80000000, hi = 0.
- Flush:
  - Flush in CALC or FIXUP goes to IDLE on the next edge. hi/lo are unchanged, done stays 0 and busy = 0 next cycle.
  - Flush in IDLE has no effect. A flush coinciding with the accepting edge wins: nothing is started.
- Simultaneous events: in FIXUP, a concurrent mdu_op is stalled. The MDU instruction is accepted the cycle after done.

Test Plan:
- MULT srca=0xFFFFFFFD (-3), srcb=5 -> busy high exactly 33 cycles, done one pulse, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then DIVU 100/7 -> lo=14, hi=2. Then DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- MULT 6*7, then MFLO presented the next cycle -> stall=1 for every cycle busy=1; in the first cycle with busy=0, stall=0 and rdata=42.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 9/0 -> lo=0xFFFFFFFF, hi=9, 33-cycle latency.
- MTHI 0x1234, MTLO 0x5678; start DIV 10/3; flush at CALC cycle 10 -> busy=0 next cycle, done never pulses, hi=0x1234, lo=0x5678.
- reset_n low asynchronously mid-CALC -> hi, lo, busy, done read 0 before the next clock edge. After release, MULTU 2*3 completes normally with lo=6, hi=0.
